// File: rtl/latch_bank_pkg.sv
// rtl/latch_bank_pkg.sv - shared op/state enums and op legality for latch_bank_writer (LATCH_BANK_PRESET_EN enables preset)
package latch_bank_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    WR  = 2'b00,
    CLR = 2'b01,
    PST = 2'b10,
    RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD
  } state_e;

  function automatic logic op_legal(op_e op);
`ifdef LATCH_BANK_PRESET_EN
    return op != RSV;
`else
    return (op == WR) || (op == CLR);
`endif
  endfunction

endpackage

// File: rtl/latch_bank_writer_if.sv
// rtl/latch_bank_writer_if.sv - request bus and latch-bank strobe bus of latch_bank_writer
interface latch_bank_writer_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  localparam int NL = 2 ** AW;

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [DW-1:0] lat_d;
  logic [NL-1:0] lat_ena;
  logic [NL-1:0] lat_rst;
  logic [NL-1:0] lat_pst;
  logic          busy;
  logic          err;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, lat_d, lat_ena, lat_rst, lat_pst, busy, err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, lat_d, lat_ena, lat_rst, lat_pst, busy, err
  );

endinterface

// File: rtl/latch_ena_decode.sv
// rtl/latch_ena_decode.sv - one-hot decode of a latch index, gated by strobe-active
module latch_ena_decode #(
  parameter int AW = 3
) (
  input  logic                i_en,
  input  logic [AW-1:0]       i_addr,
  output logic [(1<<AW)-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/latch_bank_writer.sv
// rtl/latch_bank_writer.sv - setup/open/hold strobe sequencer for a transparent-latch bank (LATCH_BANK_PRESET_EN enables preset)
module latch_bank_writer
  import latch_bank_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int OPEN_CYC = 1,
  parameter int HOLD_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  latch_bank_writer_if.slave bus
);

  localparam int NL = 2 ** AW;
  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  state_e           r_state;
  op_e              r_op;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_lat_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_err;
  logic [NL-1:0]    r_ena;
  logic [NL-1:0]    r_rst;

  op_e              w_req_op;
  logic             w_hs;
  logic             w_open_nxt;
  logic [NL-1:0]    w_ena_nxt;
  logic [NL-1:0]    w_rst_nxt;

  assign w_req_op = op_e'(bus.req_op);
  assign w_hs     = bus.req_valid && r_ready;

  // Strobes are registered one cycle ahead: decode what OPEN will look like after this edge.
  assign w_open_nxt = (r_state == SETUP) || ((r_state == OPEN) && (r_cnt != '0));

  latch_ena_decode #(.AW(AW)) u_dec_ena (
    .i_en     (w_open_nxt && (r_op == WR)),
    .i_addr   (r_addr),
    .o_onehot (w_ena_nxt)
  );

  latch_ena_decode #(.AW(AW)) u_dec_rst (
    .i_en     (w_open_nxt && (r_op == CLR)),
    .i_addr   (r_addr),
    .o_onehot (w_rst_nxt)
  );

`ifdef LATCH_BANK_PRESET_EN
  logic [NL-1:0] r_pst;
  logic [NL-1:0] w_pst_nxt;

  latch_ena_decode #(.AW(AW)) u_dec_pst (
    .i_en     (w_open_nxt && (r_op == PST)),
    .i_addr   (r_addr),
    .o_onehot (w_pst_nxt)
  );

  assign bus.lat_pst = r_pst;
`else
  assign bus.lat_pst = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= WR;
      r_addr  <= '0;
      r_lat_d <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_ena   <= '0;
      r_rst   <= '0;
`ifdef LATCH_BANK_PRESET_EN
      r_pst   <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      r_ena <= w_ena_nxt;
      r_rst <= w_rst_nxt;
`ifdef LATCH_BANK_PRESET_EN
      r_pst <= w_pst_nxt;
`endif
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_hs) begin
            if (op_legal(w_req_op)) begin
              r_state <= SETUP;
              r_ready <= 1'b0;
              r_op    <= w_req_op;
              r_addr  <= bus.req_addr;
              r_lat_d <= bus.req_data;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          r_state <= OPEN;
          r_cnt   <= OPEN_LOAD;
        end
        OPEN: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.lat_d     = r_lat_d;
  assign bus.lat_ena   = r_ena;
  assign bus.lat_rst   = r_rst;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_latch_bank_writer.sv
// tb/tb_latch_bank_writer.sv - three writer configurations checked against a request-timeline model
module tb_latch_bank_writer;

  localparam int N        = 3;
  localparam int OCS [N]  = '{1, 3, 2};
  localparam int HCS [N]  = '{1, 1, 3};
  localparam int RAND_CYC = 10000;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] op    = 2'b00;
  logic [2:0] addr  = 3'd0;
  logic [7:0] data  = 8'h00;

  logic [N-1:0]      rdy;
  logic [N-1:0]      busy;
  logic [N-1:0]      err;
  logic [N-1:0][7:0] o_d;
  logic [N-1:0][7:0] o_ena;
  logic [N-1:0][7:0] o_rst;
  logic [N-1:0][7:0] o_pst;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    latch_bank_writer_if #(.DW(8), .AW(3)) bus ();
    assign bus.req_valid = valid;
    assign bus.req_op    = op;
    assign bus.req_addr  = addr;
    assign bus.req_data  = data;
    assign rdy[g]   = bus.req_ready;
    assign busy[g]  = bus.busy;
    assign err[g]   = bus.err;
    assign o_d[g]   = bus.lat_d;
    assign o_ena[g] = bus.lat_ena;
    assign o_rst[g] = bus.lat_rst;
    assign o_pst[g] = bus.lat_pst;
    latch_bank_writer #(.DW(8), .AW(3), .OPEN_CYC(OCS[g]), .HOLD_CYC(HCS[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: last legal accept edge per instance; outputs follow from edge arithmetic.
  int         acc    [N];
  int         n_acc  [N];
  bit         pend   [N];
  bit         m_rdy  [N];
  bit         m_err  [N];
  logic [7:0] m_d    [N];
  logic [1:0] m_op   [N];
  logic [2:0] m_addr [N];
  logic [7:0] mb     [N][8];
  logic [7:0] ob     [N][8];

  function automatic bit legal(logic [1:0] o);
`ifdef LATCH_BANK_PRESET_EN
    return o != 2'b11;
`else
    return o[1] == 1'b0;
`endif
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s[%0d] cycle %0d: got 0x%0h expected 0x%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [1:0] o, logic [2:0] a, logic [7:0] d);
    valid = v;
    op    = o;
    addr  = a;
    data  = d;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        pend[k]  = 1'b0;
        m_rdy[k] = 1'b0;
        m_err[k] = 1'b0;
        m_d[k]   = 8'h00;
      end else begin
        m_err[k] = 1'b0;
        if (valid && m_rdy[k]) begin
          if (legal(op)) begin
            pend[k]   = 1'b1;
            acc[k]    = cyc;
            n_acc[k]  = n_acc[k] + 1;
            m_d[k]    = data;
            m_op[k]   = op;
            m_addr[k] = addr;
            case (op)
              2'b00:   mb[k][addr] = data;
              2'b01:   mb[k][addr] = 8'h00;
              default: mb[k][addr] = 8'hFF;
            endcase
          end else begin
            m_err[k] = 1'b1;
          end
        end
        m_rdy[k] = !(pend[k] && (cyc < acc[k] + 1 + OCS[k] + HCS[k]));
      end
    end
  end

  bit         ce_act;
  logic [7:0] ce_vec;

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < N; k++) begin
        ce_act = pend[k] && (cyc >= acc[k] + 1) && (cyc <= acc[k] + OCS[k]);
        ce_vec = 8'h01 << m_addr[k];
        chk("ready", k, rdy[k], m_rdy[k]);
        chk("busy", k, busy[k], pend[k] && (cyc < acc[k] + 1 + OCS[k] + HCS[k]));
        chk("err", k, err[k], m_err[k]);
        chk("lat_d", k, o_d[k], m_d[k]);
        chk("lat_ena", k, o_ena[k], (ce_act && m_op[k] == 2'b00) ? ce_vec : 8'h00);
        chk("lat_rst", k, o_rst[k], (ce_act && m_op[k] == 2'b01) ? ce_vec : 8'h00);
        chk("lat_pst", k, o_pst[k], (ce_act && m_op[k] == 2'b10) ? ce_vec : 8'h00);
        chk("onehot", k, $countones({o_ena[k], o_rst[k], o_pst[k]}) <= 1, 1);
        for (int a = 0; a < 8; a++) begin
          if (o_ena[k][a]) ob[k][a] = o_d[k];
          if (o_rst[k][a]) ob[k][a] = 8'h00;
          if (o_pst[k][a]) ob[k][a] = 8'hFF;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      acc[k]   = 0;
      n_acc[k] = 0;
      pend[k]  = 1'b0;
      m_rdy[k] = 1'b0;
      m_err[k] = 1'b0;
      m_d[k]   = 8'h00;
      m_op[k]  = 2'b00;
      m_addr[k] = 3'd0;
      for (int a = 0; a < 8; a++) begin
        mb[k][a] = 8'h00;
        ob[k][a] = 8'h00;
      end
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("lit_rst_ready", 0, rdy[0], 0);
    chk("lit_rst_busy", 0, busy[0], 0);
    chk("lit_rst_latd", 0, o_d[0], 8'h00);
    chk("lit_rst_strobes", 0, {o_ena[0], o_rst[0], o_pst[0]}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_ready_after_rst", 0, rdy[0], 1);

    // write addr 5 data A5, handshake at edge T
    drive(1'b1, 2'b00, 3'd5, 8'hA5);
    @(negedge clk);
    valid = 1'b0;
    chk("lit_wr_latd_t1", 0, o_d[0], 8'hA5);
    chk("lit_wr_ena_t1", 0, o_ena[0], 8'h00);
    chk("lit_wr_ready_t1", 0, rdy[0], 0);
    @(negedge clk);
    chk("lit_wr_ena_t2", 0, o_ena[0], 8'h20);
    @(negedge clk);
    chk("lit_wr_ena_t3", 0, o_ena[0], 8'h00);
    chk("lit_wr_latd_t3", 0, o_d[0], 8'hA5);
    chk("lit_wr_ready_t3", 0, rdy[0], 0);
    @(negedge clk);
    chk("lit_wr_ready_t4", 0, rdy[0], 1);
    repeat (10) @(negedge clk);

    // clear addr 0 with req_valid held; second request carries new data
    drive(1'b1, 2'b01, 3'd0, 8'h11);
    @(negedge clk);
    data = 8'h22;
    chk("lit_clr_latd_t1", 0, o_d[0], 8'h11);
    @(negedge clk);
    chk("lit_clr_rst_t2", 0, o_rst[0], 8'h01);
    @(negedge clk);
    chk("lit_clr_rst_t3", 0, o_rst[0], 8'h00);
    chk("lit_clr_ready_t3", 0, rdy[0], 0);
    @(negedge clk);
    chk("lit_clr_ready_t4", 0, rdy[0], 1);
    chk("lit_clr_latd_t4", 0, o_d[0], 8'h11);
    @(negedge clk);
    chk("lit_clr_second_busy", 0, busy[0], 1);
    chk("lit_clr_second_latd", 0, o_d[0], 8'h22);
    valid = 1'b0;
    repeat (12) @(negedge clk);

    // preset addr 7
    drive(1'b1, 2'b10, 3'd7, 8'h5A);
    @(negedge clk);
    valid = 1'b0;
`ifdef LATCH_BANK_PRESET_EN
    chk("lit_pst_t1", 0, o_pst[0], 8'h00);
    @(negedge clk);
    chk("lit_pst_t2", 0, o_pst[0], 8'h80);
`else
    chk("lit_pst_err", 0, err[0], 1);
    chk("lit_pst_ready", 0, rdy[0], 1);
    chk("lit_pst_busy", 0, busy[0], 0);
    @(negedge clk);
    chk("lit_pst_err_end", 0, err[0], 0);
    chk("lit_pst_none", 0, o_pst[0], 8'h00);
`endif
    repeat (12) @(negedge clk);

    // reserved op
    drive(1'b1, 2'b11, 3'd3, 8'h77);
    @(negedge clk);
    valid = 1'b0;
    chk("lit_rsv_err", 0, err[0], 1);
    chk("lit_rsv_busy", 0, busy[0], 0);
    chk("lit_rsv_strobes", 0, {o_ena[0], o_rst[0], o_pst[0]}, 0);
    @(negedge clk);
    chk("lit_rsv_err_end", 0, err[0], 0);
    repeat (4) @(negedge clk);

    // reset in the first OPEN cycle of the OPEN_CYC=3 instance
    drive(1'b1, 2'b00, 3'd2, 8'h3C);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("lit_ro_ena_open", 1, o_ena[1], 8'h04);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_ro_ena_cut", 1, o_ena[1], 8'h00);
    chk("lit_ro_latd", 1, o_d[1], 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_ro_ready", 1, rdy[1], 1);

    // random traffic; latch-bank contents rebuilt from observed strobes
    for (int k = 0; k < N; k++) begin
      n_acc[k] = 0;
      for (int a = 0; a < 8; a++) begin
        mb[k][a] = 8'h00;
        ob[k][a] = 8'h00;
      end
    end
    repeat (RAND_CYC) begin
      drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 8'($urandom));
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 8; a++)
        chk("bank", k, ob[k][a], mb[k][a]);
    chk("traffic_volume", 2, n_acc[2] > 500, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/latch_bank_writer.md
LATCH_BANK_WRITER -- requirements
Module: latch_bank_writer

Interface
REQ-001 SHALL have parameter DW, default 8, meaning latch data width.
REQ-002 SHALL have parameter AW, default 3, meaning address width; the bank has NL = 2**AW latches.
REQ-003 SHALL have parameter OPEN_CYC, default 1, meaning number of cycles a strobe is held high (legal range 1..15).
REQ-004 SHALL have parameter HOLD_CYC, default 1, meaning number of cycles lat_d is held after the strobe falls (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit, the system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset rst, synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1 bit, request present.
REQ-008 SHALL have port req_ready, output, 1 bit, writer can accept a request.
REQ-009 SHALL have port req_op, input, 2 bits, with encoding 00 write, 01 clear, 10 preset, 11 reserved.
REQ-010 SHALL have port req_addr, input, AW bits, target latch index.
REQ-011 SHALL have port req_data, input, DW bits, write data.
REQ-012 SHALL have port lat_d, output, DW bits, shared data bus to all latches.
REQ-013 SHALL have port lat_ena, output, NL bits, per-latch transparent enable.
REQ-014 SHALL have port lat_rst, output, NL bits, per-latch clear.
REQ-015 SHALL have port lat_pst, output, NL bits, per-latch preset.
REQ-016 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-017 SHALL have port err, output, 1 bit, one-cycle pulse on a rejected op.

Function
REQ-018 SHALL have FSM states IDLE, SETUP, OPEN and HOLD.
REQ-019 SHALL assert req_ready only in IDLE; a handshake occurs when req_valid and req_ready are both high at a rising edge.
REQ-020 On handshake in IDLE with a legal op, SHALL register op, addr and data, and go to SETUP.
REQ-021 In SETUP, SHALL last exactly 1 cycle, drive lat_d with the registered data and keep all strobes low.
REQ-022 In OPEN, SHALL last OPEN_CYC cycles and drive high exactly one strobe bit at index addr: lat_ena for write, lat_rst for clear, lat_pst for preset.
REQ-023 In HOLD, SHALL last HOLD_CYC cycles with all strobes low and lat_d unchanged, then return to IDLE.
REQ-024 SHALL meet the following latency for a handshake at edge T: strobe high from T+2 through T+1+OPEN_CYC, and req_ready high again at T+2+OPEN_CYC+HOLD_CYC.
REQ-025 SHALL never have more than one bit high across lat_ena, lat_rst and lat_pst combined.
REQ-026 SHALL hold lat_d constant from SETUP entry until HOLD exit; lat_d is don't-care only in IDLE but holds its last value there.
REQ-027 SHALL drive all strobes and lat_d directly from flops, with no combinational path from any input, so that latch enables are glitch-free.
REQ-028 A reserved op at handshake SHALL pulse err for exactly 1 cycle, produce no strobe, and leave the FSM in IDLE.
REQ-029 SHALL use a single down-counter of 4 bits for OPEN and HOLD durations.
REQ-030 SHALL ignore req_valid while busy; inputs are not sampled outside IDLE.

Reset
REQ-031 While rst is high at an edge, SHALL force the following: state IDLE, all strobes 0, lat_d 0, err 0, busy 0, req_ready 0, counter 0.
REQ-032 SHALL have req_ready rise in the first cycle after rst deasserts.
REQ-033 A reset during OPEN SHALL drop the strobe at that same edge, with no partial write retried afterwards.

Configuration
REQ-034 With macro LATCH_BANK_PRESET_EN defined, SHALL support the preset op per REQ-022.
REQ-035 Without LATCH_BANK_PRESET_EN, SHALL treat op 10 as reserved per REQ-028 and tie lat_pst to constant 0.

Structure
REQ-036 SHALL take the op enum type (WR, CLR, PST, RSV) and the FSM state enum from shared package latch_bank_pkg.
REQ-037 SHALL place the one-hot index decode (addr to NL-bit vector, gated by strobe-active) in sub-module latch_ena_decode, instantiated three times or muxed by op.

Verification
REQ-038 SHALL cover this scenario: write op=00 addr=5 data=0xA5 with OPEN_CYC=1, HOLD_CYC=1 -> lat_ena=0x20 for exactly 1 cycle at T+2, lat_d=0xA5 from T+1 to T+3, req_ready at T+4.
REQ-039 SHALL cover this scenario: clear addr=0 followed by a held req_valid -> lat_rst=0x01 for 1 cycle; the second request is accepted only at T+4.
REQ-040 SHALL cover this scenario: preset addr=7 with the macro defined -> lat_pst=0x80; without the macro -> err pulse for 1 cycle, no strobe, req_ready stays 1.
REQ-041 SHALL cover this scenario: op=11 -> err=1 for 1 cycle, busy=0, all strobes 0.
REQ-042 SHALL cover this scenario: rst asserted in the first OPEN cycle with OPEN_CYC=3 -> strobes 0 at the next edge, lat_d=0, req_ready=1 one cycle after rst falls.
REQ-043 SHALL cover this scenario: random traffic of 10k requests with OPEN_CYC=2, HOLD_CYC=3 -> assertions for REQ-025 and REQ-026 never fire, and a behavioural latch-bank model matches the expected contents.
